// File: rtl/bank_pkg.sv
// bank_pkg: shared constants and pointer-width helper for the bank_nport data bank.
package bank_pkg;
   localparam int CONFLICT_CNT_W = 16;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bank_rr_arbiter.sv
// bank_rr_arbiter: combinational round-robin arbiter, lowest requester at or above ptr wins, wrapping to 0.
module bank_rr_arbiter import bank_pkg::*; #(
   parameter int NWR = 3,
   parameter int PW  = ptr_w(NWR)
) (
   input  logic [NWR-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [NWR-1:0] grant,
   output logic [PW-1:0]  winner
);
   logic [NWR-1:0] mask, pick;
   always_comb begin
      mask = '0;
      for (int i = 0; i < NWR; i++) mask[i] = (i >= int'(ptr));
      pick = |(req & mask) ? (req & mask) : req;
      grant = pick & ~(pick - NWR'(1));
      winner = '0;
      for (int i = 0; i < NWR; i++) winner = grant[i] ? PW'(i) : winner;
   end
endmodule

// File: rtl/ram_simple2port.sv
// ram_simple2port: generic simple-dual-port RAM, registered read-first output, no reset on contents.
module ram_simple2port #(
   parameter int W = 64,
   parameter int A = 10
) (
   input  logic         clk,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [W-1:0] wdata,
   input  logic         re,
   input  logic [A-1:0] raddr,
   output logic [W-1:0] rdata
);
   logic [W-1:0] mem [2**A];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/bank_nport.sv
// bank_nport: NWR-channel round-robin write, broadcast read (RD_LAT 1/2) data bank.
// BANK_WR_BYPASS_EN selects write-first forwarding on same-address read/write; default is read-first.
module bank_nport import bank_pkg::*; #(
   parameter int W      = 64,
   parameter int A      = 10,
   parameter int NWR    = 3,
   parameter int RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rd_en,
   input  logic [A-1:0]              rd_addr,
   output logic [W-1:0]              rd_word,
   output logic                      rd_valid,
   input  logic [NWR-1:0]            wr_req,
   input  logic [NWR*A-1:0]          wr_addr,
   input  logic [NWR*W-1:0]          wr_word,
   output logic [NWR-1:0]            wr_grant,
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);
   localparam int PW = ptr_w(NWR);
   logic [PW-1:0]  ptr, winner;
   logic [NWR-1:0] arb_grant;
   logic           we;
   logic [A-1:0]   waddr;
   logic [W-1:0]   wdata, ram_q, rd_data1, out_word;

   bank_rr_arbiter #(.NWR(NWR), .PW(PW)) u_arb (
      .req(wr_req), .ptr(ptr), .grant(arb_grant), .winner(winner)
   );

   // grants are masked during reset so no RAM write can slip through
   assign wr_grant = rst ? '0 : arb_grant;
   assign we       = |wr_grant;
   assign waddr    = wr_addr[winner*A +: A];
   assign wdata    = wr_word[winner*W +: W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         conflict_cnt <= '0;
      end else begin
         if (we) ptr <= (int'(winner) == NWR - 1) ? '0 : winner + PW'(1);
         if ($countones(wr_req) > 1 && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + CONFLICT_CNT_W'(1);
      end
   end

`ifdef INTEL
   intel_ram_simple2port #(.W(W), .A(A)) u_ram (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .re(rd_en), .raddr(rd_addr), .rdata(ram_q)
   );
`elsif XILINX_BRAM_IP
   xilinx_bram_sdp #(.W(W), .A(A)) u_ram (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .re(rd_en), .raddr(rd_addr), .rdata(ram_q)
   );
`elsif LIB
   lib_ram_simple2port #(.W(W), .A(A)) u_ram (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .re(rd_en), .raddr(rd_addr), .rdata(ram_q)
   );
`else
   ram_simple2port #(.W(W), .A(A)) u_ram (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .re(rd_en), .raddr(rd_addr), .rdata(ram_q)
   );
`endif

`ifdef BANK_WR_BYPASS_EN
   logic         byp_hit;
   logic [W-1:0] byp_word;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) byp_hit <= 1'b0;
      else     byp_hit <= rd_en && we && (rd_addr == waddr);
   end
   always_ff @(posedge clk) begin
      byp_word <= wdata;
   end
   assign rd_data1 = byp_hit ? byp_word : ram_q;
`else
   assign rd_data1 = ram_q;
`endif

   generate
      if (RD_LAT == RD_LAT_MAX) begin : g_lat2
         logic         v1, v2;
         logic [W-1:0] d2;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v1 <= 1'b0;
               v2 <= 1'b0;
               d2 <= '0;
            end else begin
               v1 <= rd_en;
               v2 <= v1;
               d2 <= rd_data1;
            end
         end
         assign rd_valid = v2;
         assign out_word = d2;
      end else begin : g_lat1
         logic v1;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) v1 <= 1'b0;
            else     v1 <= rd_en;
         end
         assign rd_valid = v1;
         assign out_word = rd_data1;
      end
   endgenerate

   assign rd_word = rd_valid ? out_word : '0;
endmodule

// File: tb/tb_bank_nport.sv
// tb_bank_nport: directed checks of bank_nport at RD_LAT=1, RD_LAT=2 and NWR=1 (BANK_WR_BYPASS_EN aware).
module tb_bank_nport;
   localparam int W = 64;
   localparam int A = 10;
   localparam int N = 3;
`ifdef BANK_WR_BYPASS_EN
   localparam logic [W-1:0] EXP_COLL = 64'h2222;
`else
   localparam logic [W-1:0] EXP_COLL = 64'h1111;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rd_en = 1'b0;
   logic [A-1:0]   rd_addr = '0;
   logic [N-1:0]   wr_req = '0;
   logic [N*A-1:0] wr_addr = '0;
   logic [N*W-1:0] wr_word = '0;

   logic [W-1:0] rw1, rw2, rw0;
   logic         rv1, rv2, rv0;
   logic [N-1:0] g1, g2;
   logic [0:0]   g0;
   logic [15:0]  c1, c2, c0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bank_nport #(.W(W), .A(A), .NWR(N), .RD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rw1), .rd_valid(rv1),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_word(wr_word), .wr_grant(g1), .conflict_cnt(c1)
   );
   bank_nport #(.W(W), .A(A), .NWR(N), .RD_LAT(2)) u2 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rw2), .rd_valid(rv2),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_word(wr_word), .wr_grant(g2), .conflict_cnt(c2)
   );
   bank_nport #(.W(W), .A(A), .NWR(1), .RD_LAT(1)) u0 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rw0), .rd_valid(rv0),
      .wr_req(wr_req[0]), .wr_addr(wr_addr[A-1:0]), .wr_word(wr_word[W-1:0]), .wr_grant(g0), .conflict_cnt(c0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [A-1:0] a, input logic [W-1:0] d);
      wr_addr[i*A +: A] = a;
      wr_word[i*W +: W] = d;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      wr_req = 3'b111;
      tick;
      tick;
      n_cmp++;
      if ({g1, g2} !== 6'b0) begin
         $display("FAIL reset_grant: got g1=%b g2=%b want 000", g1, g2);
         n_err++;
      end
      wr_req = '0;
      rst = 1'b0;
      tick;
      rd_en = 1'b1;
      rd_addr = '0;
      tick;
      rd_en = 1'b0;
      n_cmp++;
      if (rv2 !== 1'b0) begin
         $display("FAIL reset_lat2_early: got rd_valid=%b want 0", rv2);
         n_err++;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({rv1, rw1} !== {1'b0, 64'h0}) begin
         $display("FAIL reset_async: got valid=%b word=%h want 0/0", rv1, rw1);
         n_err++;
      end
      tick;
      rst = 1'b0;
      for (int t = 0; t < 4; t++) begin
         n_cmp++;
         if ({rv2, rw2} !== {1'b0, 64'h0}) begin
            $display("FAIL reset_drop t=%0d: got valid=%b word=%h want 0/0", t, rv2, rw2);
            n_err++;
         end
         tick;
      end
      n_cmp++;
      if (c2 !== 16'h0) begin
         $display("FAIL reset_cnt: got %h want 0000", c2);
         n_err++;
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] exp_g [3];
      exp_g[0] = 3'b001;
      exp_g[1] = 3'b010;
      exp_g[2] = 3'b100;
      set_ch(0, 10'd10, 64'hA0);
      set_ch(1, 10'd11, 64'hA1);
      set_ch(2, 10'd12, 64'hA2);
      wr_req = 3'b111;
      for (int t = 0; t < 3; t++) begin
         #1;
         n_cmp++;
         if (g2 !== exp_g[t] || g1 !== exp_g[t]) begin
            $display("FAIL rr_grant t=%0d: got %b/%b want %b", t, g1, g2, exp_g[t]);
            n_err++;
         end
         n_cmp++;
         if (g0 !== 1'b1) begin
            $display("FAIL nwr1_grant t=%0d: got %b want 1", t, g0);
            n_err++;
         end
         tick;
      end
      wr_req = '0;
      #1;
      n_cmp++;
      if (g2 !== 3'b000) begin
         $display("FAIL rr_idle: got %b want 000", g2);
         n_err++;
      end
      n_cmp++;
      if (c1 !== 16'd3 || c2 !== 16'd3 || c0 !== 16'd0) begin
         $display("FAIL rr_cnt: got %0d/%0d/%0d want 3/3/0", c1, c2, c0);
         n_err++;
      end
      rd_en = 1'b1;
      rd_addr = 10'd11;
      tick;
      rd_en = 1'b0;
      n_cmp++;
      if ({rv1, rw1} !== {1'b1, 64'hA1}) begin
         $display("FAIL rr_read_lat1: got %b/%h want 1/a1", rv1, rw1);
         n_err++;
      end
      tick;
      n_cmp++;
      if ({rv2, rw2} !== {1'b1, 64'hA1}) begin
         $display("FAIL rr_read_lat2: got %b/%h want 1/a1", rv2, rw2);
         n_err++;
      end
   endtask

   task automatic test_write_read;
      set_ch(1, 10'h3FF, 64'hDEAD_BEEF_0000_0001);
      wr_req = 3'b010;
      #1;
      n_cmp++;
      if (g2 !== 3'b010) begin
         $display("FAIL wr_grant: got %b want 010", g2);
         n_err++;
      end
      tick;
      wr_req = '0;
      rd_en = 1'b1;
      rd_addr = 10'h3FF;
      tick;
      rd_en = 1'b0;
      n_cmp++;
      if ({rv1, rw1, rv2, rw2} !== {1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0}) begin
         $display("FAIL wr_read_c1: got %b/%h %b/%h want 1/deadbeef00000001 0/0", rv1, rw1, rv2, rw2);
         n_err++;
      end
      tick;
      n_cmp++;
      if ({rv1, rw1, rv2, rw2} !== {1'b0, 64'h0, 1'b1, 64'hDEAD_BEEF_0000_0001}) begin
         $display("FAIL wr_read_c2: got %b/%h %b/%h want 0/0 1/deadbeef00000001", rv1, rw1, rv2, rw2);
         n_err++;
      end
   endtask

   task automatic test_collision;
      set_ch(0, 10'd5, 64'h1111);
      wr_req = 3'b001;
      #1;
      n_cmp++;
      if (g2 !== 3'b001) begin
         $display("FAIL coll_wrap_grant: got %b want 001", g2);
         n_err++;
      end
      tick;
      set_ch(0, 10'd5, 64'h2222);
      rd_en = 1'b1;
      rd_addr = 10'd5;
      tick;
      wr_req = '0;
      n_cmp++;
      if (rw1 !== EXP_COLL) begin
         $display("FAIL coll_same_lat1: got %h want %h", rw1, EXP_COLL);
         n_err++;
      end
      tick;
      rd_en = 1'b0;
      n_cmp++;
      if (rw1 !== 64'h2222 || rw2 !== EXP_COLL) begin
         $display("FAIL coll_next: got %h/%h want 2222/%h", rw1, rw2, EXP_COLL);
         n_err++;
      end
      tick;
      n_cmp++;
      if (rw2 !== 64'h2222) begin
         $display("FAIL coll_after_lat2: got %h want 2222", rw2);
         n_err++;
      end
   endtask

   task automatic test_streaming;
      wr_req = 3'b100;
      for (int i = 0; i < 8; i++) begin
         set_ch(2, A'(i), 64'h100 + 64'(i));
         tick;
      end
      wr_req = '0;
      for (int t = 0; t < 12; t++) begin
         rd_en = (t < 8);
         rd_addr = A'(t);
         #1;
         n_cmp++;
         if ({rv1, rw1} !== ((t >= 1 && t <= 8) ? {1'b1, 64'h100 + 64'(t - 1)} : {1'b0, 64'h0})) begin
            $display("FAIL stream_lat1 t=%0d: got %b/%h", t, rv1, rw1);
            n_err++;
         end
         n_cmp++;
         if ({rv2, rw2} !== ((t >= 2 && t <= 9) ? {1'b1, 64'h100 + 64'(t - 2)} : {1'b0, 64'h0})) begin
            $display("FAIL stream_lat2 t=%0d: got %b/%h", t, rv2, rw2);
            n_err++;
         end
         tick;
      end
   endtask

   task automatic test_saturation;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_cmp++;
      if (c2 !== 16'h0) begin
         $display("FAIL sat_start: got %h want 0000", c2);
         n_err++;
      end
      set_ch(0, 10'd20, 64'h20);
      set_ch(1, 10'd21, 64'h21);
      wr_req = 3'b011;
      repeat (65534) tick;
      n_cmp++;
      if (c2 !== 16'hFFFE) begin
         $display("FAIL sat_near: got %h want fffe", c2);
         n_err++;
      end
      repeat (6) tick;
      wr_req = '0;
      n_cmp++;
      if (c1 !== 16'hFFFF || c2 !== 16'hFFFF || c0 !== 16'h0) begin
         $display("FAIL sat_hold: got %h/%h/%h want ffff/ffff/0000", c1, c2, c0);
         n_err++;
      end
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_write_read;
      test_collision;
      test_streaming;
      test_saturation;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
